// File: rtl/gpio_port.sv
// GPIO port: register-mapped pins, synchronised + debounced inputs, edge-triggered level IRQ.
// Pad->DIN in SYNC_STAGES+max(DEB_CYCLES,1) edges; RDATA one cycle after RE; no backpressure, one access per strobe.
module gpio_port #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic             CK,
    input  logic             RSTN,
    inout  wire  [WIDTH-1:0] PAD,
    input  logic [2:0]       ADDR,
    input  logic             WE,
    input  logic             RE,
    input  logic [WIDTH-1:0] WDATA,
    output logic [WIDTH-1:0] RDATA,
    output logic             IRQ
);

    localparam logic [2:0] A_DOUT    = 3'd0;
    localparam logic [2:0] A_OE      = 3'd1;
    localparam logic [2:0] A_DIN     = 3'd2;
    localparam logic [2:0] A_RISE_EN = 3'd3;
    localparam logic [2:0] A_FALL_EN = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;
    localparam logic [2:0] A_SET     = 3'd6;
    localparam logic [2:0] A_CLR     = 3'd7;

    // Counter only needs to reach DEB_CYCLES-1; the next differing cycle toggles DIN.
    localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = (DEB_CYCLES > 0) ? CW'(DEB_CYCLES - 1) : '0;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] sync_o;

    logic [WIDTH-1:0] din_q,     din_d;
    logic [WIDTH-1:0] dout_q,    dout_d;
    logic [WIDTH-1:0] oe_q,      oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q,  status_d;
    logic [WIDTH-1:0] rdata_q,   rdata_d;
    logic             irq_q,     irq_d;

    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign PAD[i] = oe_q[i] ? dout_q[i] : 1'bz;
    end

    always_comb begin
        sync_d[0] = PAD;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sync_o = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        din_d = din_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
        end
        if (DEB_CYCLES == 0) begin
            din_d = sync_o;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_o[i] != din_q[i]) begin
                    if (cnt_q[i] == DEB_LAST) begin
                        din_d[i] = sync_o[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        dout_d    = dout_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (WE) begin
            case (ADDR)
                A_DOUT:    dout_d    = WDATA;
                A_OE:      oe_d      = WDATA;
                A_RISE_EN: rise_en_d = WDATA;
                A_FALL_EN: fall_en_d = WDATA;
                A_STATUS:  w1c       = WDATA;
                A_SET:     dout_d    = dout_q | WDATA;
                A_CLR:     dout_d    = dout_q & ~WDATA;
                default:   ;
            endcase
        end

        // New events are ORed in after the clear so a same-cycle event survives W1C.
        rise_ev  = din_d & ~din_q & rise_en_q;
        fall_ev  = ~din_d & din_q & fall_en_q;
        status_d = (status_q & ~w1c) | rise_ev | fall_ev;
        irq_d    = |status_d;

        rdata_d = rdata_q;
        if (RE) begin
            case (ADDR)
                A_DOUT:    rdata_d = dout_q;
                A_OE:      rdata_d = oe_q;
                A_DIN:     rdata_d = din_q;
                A_RISE_EN: rdata_d = rise_en_q;
                A_FALL_EN: rdata_d = fall_en_q;
                A_STATUS:  rdata_d = status_q;
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            din_q     <= '0;
            dout_q    <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            din_q     <= din_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign RDATA = rdata_q;
    assign IRQ   = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_gpio_port;
    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic         ck = 1'b0;
    logic         rstn = 1'b0;
    logic [2:0]   addr = '0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] tb_en = '1;
    logic [W-1:0] tb_val = '0;
    wire  [W-1:0] pad;
    wire  [W-1:0] pad0;
    logic [W-1:0] rdata, rdata0;
    logic         irq, irq0;

    int n_run = 0;
    int n_fail = 0;

    always #5 ck = ~ck;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pad[i]  = tb_en[i] ? tb_val[i] : 1'bz;
        assign pad0[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_port #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(D)) u_dut (
        .CK(ck), .RSTN(rstn), .PAD(pad), .ADDR(addr), .WE(we), .RE(re),
        .WDATA(wdata), .RDATA(rdata), .IRQ(irq)
    );

    gpio_port #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(0)) u_dut0 (
        .CK(ck), .RSTN(rstn), .PAD(pad0), .ADDR(addr), .WE(we), .RE(re),
        .WDATA(wdata), .RDATA(rdata0), .IRQ(irq0)
    );

    // Reference model of u_dut: pad history, per-bit persistence run lengths, register file.
    logic [W-1:0] m_dout = '0, m_oe = '0, m_rise = '0, m_fall = '0;
    logic [W-1:0] m_status = '0, m_rdata = '0, m_din = '0;
    logic [W-1:0] m_hist [S];
    int           m_run [W];

    function automatic logic [W-1:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0:    return m_dout;
            3'd1:    return m_oe;
            3'd2:    return m_din;
            3'd3:    return m_rise;
            3'd4:    return m_fall;
            3'd5:    return m_status;
            default: return '0;
        endcase
    endfunction

    initial forever begin
        logic [W-1:0] padv, seen, nd, evs, w1c;
        @(posedge ck or negedge rstn);
        if (!rstn) begin
            m_dout = '0; m_oe = '0; m_rise = '0; m_fall = '0;
            m_status = '0; m_rdata = '0; m_din = '0;
            for (int k = 0; k < S; k++) m_hist[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            padv = (m_oe & m_dout) | (~m_oe & tb_en & tb_val);
            seen = m_hist[S-1];
            nd   = m_din;
            for (int i = 0; i < W; i++) begin
                if (seen[i] != m_din[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= D) begin
                        nd[i] = seen[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (re) m_rdata = m_reg(addr);
            evs = (nd & ~m_din & m_rise) | (~nd & m_din & m_fall);
            w1c = (we && addr == 3'd5) ? wdata : '0;
            m_status = (m_status & ~w1c) | evs;
            if (we) begin
                case (addr)
                    3'd0: m_dout = wdata;
                    3'd1: m_oe = wdata;
                    3'd3: m_rise = wdata;
                    3'd4: m_fall = wdata;
                    3'd6: m_dout = m_dout | wdata;
                    3'd7: m_dout = m_dout & ~wdata;
                    default: ;
                endcase
            end
            m_din = nd;
            for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = padv;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge ck);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [W-1:0] d);
        addr = a; re = 1'b1;
        @(negedge ck);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        repeat (2) @(negedge ck);
        n_run++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_run++; if (pad !== 8'h00) begin n_fail++; $display("FAIL reset_pad: got %h want 00", pad); end
        rstn = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            n_run++; if (d !== '0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 00", a, d); end
        end
    endtask

    task automatic test_regs();
        logic [W-1:0] d;
        wr(3'd0, 8'hA5);
        tb_val = 8'hA5;
        wr(3'd1, 8'hFF);
        tb_en = '0;
        n_run++; if (pad !== 8'hA5) begin n_fail++; $display("FAIL pad_dout: got %h want a5", pad); end
        wr(3'd6, 8'h0A);
        n_run++; if (pad !== 8'hAF) begin n_fail++; $display("FAIL pad_set: got %h want af", pad); end
        wr(3'd7, 8'h01);
        n_run++; if (pad !== 8'hAE) begin n_fail++; $display("FAIL pad_clr: got %h want ae", pad); end
        rd(3'd0, d);
        n_run++; if (d !== 8'hAE) begin n_fail++; $display("FAIL rd_dout: got %h want ae", d); end
        rd(3'd6, d);
        n_run++; if (d !== 8'h00) begin n_fail++; $display("FAIL rd_set: got %h want 00", d); end
        rd(3'd7, d);
        n_run++; if (d !== 8'h00) begin n_fail++; $display("FAIL rd_clr: got %h want 00", d); end
        repeat (8) @(negedge ck);
        rd(3'd2, d);
        n_run++; if (d !== 8'hAE) begin n_fail++; $display("FAIL din_loopback: got %h want ae", d); end
        wr(3'd2, 8'h00);
        rd(3'd2, d);
        n_run++; if (d !== 8'hAE) begin n_fail++; $display("FAIL din_write_ignored: got %h want ae", d); end
        tb_val = 8'hAE; tb_en = '1;
        wr(3'd1, 8'h00);
        tb_val = '0;
        repeat (10) @(negedge ck);
    endtask

    task automatic test_rise_latency();
        logic [W-1:0] d;
        wr(3'd3, 8'h01);
        tb_val = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            @(negedge ck);
            n_run++;
            if (irq !== (k == 6)) begin n_fail++; $display("FAIL rise_latency_edge%0d: got %b want %b", k, irq, k == 6); end
        end
        rd(3'd5, d);
        n_run++; if (d !== 8'h01) begin n_fail++; $display("FAIL rise_status: got %h want 01", d); end
        rd(3'd2, d);
        n_run++; if (d !== 8'h01) begin n_fail++; $display("FAIL rise_din: got %h want 01", d); end
    endtask

    task automatic test_glitch();
        logic [W-1:0] d;
        wr(3'd3, 8'h00);
        n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL en_clear_keeps_status: got %b want 1", irq); end
        tb_val = '0;
        repeat (10) @(negedge ck);
        wr(3'd5, 8'h01);
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: got %b want 0", irq); end
        wr(3'd3, 8'h01);
        tb_val = 8'h01;
        repeat (3) @(negedge ck);
        tb_val = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ck);
            n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch3_irq_c%0d: got %b want 0", k, irq); end
        end
        rd(3'd2, d);
        n_run++; if (d !== 8'h00) begin n_fail++; $display("FAIL glitch3_din: got %h want 00", d); end
        tb_val = 8'h01;
        repeat (4) @(negedge ck);
        tb_val = '0;
        repeat (12) @(negedge ck);
        n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pulse4_irq: got %b want 1", irq); end
        rd(3'd2, d);
        n_run++; if (d !== 8'h00) begin n_fail++; $display("FAIL pulse4_din_back: got %h want 00", d); end
    endtask

    task automatic test_w1c_race();
        logic [W-1:0] d;
        tb_val = 8'h01;
        repeat (10) @(negedge ck);
        wr(3'd4, 8'h01);
        tb_val = '0;
        repeat (5) @(negedge ck);
        addr = 3'd5; wdata = 8'h01; we = 1'b1;
        @(negedge ck);
        we = 1'b0;
        n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq: got %b want 1", irq); end
        rd(3'd5, d);
        n_run++; if (d !== 8'h01) begin n_fail++; $display("FAIL race_status: got %h want 01", d); end
        wr(3'd5, 8'h01);
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL race_later_clear: got %b want 0", irq); end
    endtask

    task automatic test_deb0();
        wr(3'd5, 8'hFF);
        tb_val = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            @(negedge ck);
            n_run++;
            if (irq0 !== (k == 3)) begin n_fail++; $display("FAIL deb0_edge%0d: got %b want %b", k, irq0, k == 3); end
        end
        wr(3'd5, 8'hFF);
        n_run++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL deb0_w1c_irq: got %b want 0", irq0); end
        addr = 3'd5; re = 1'b1;
        @(negedge ck);
        re = 1'b0;
        n_run++; if (rdata0 !== 8'h00) begin n_fail++; $display("FAIL deb0_status: got %h want 00", rdata0); end
        addr = 3'd2; re = 1'b1;
        @(negedge ck);
        re = 1'b0;
        n_run++; if (rdata0 !== 8'h01) begin n_fail++; $display("FAIL deb0_din: got %h want 01", rdata0); end
        tb_val = '0;
        repeat (10) @(negedge ck);
        wr(3'd5, 8'hFF);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h00);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge ck);
            n_run++; if (irq !== (|m_status)) begin n_fail++; $display("FAIL rand_irq_c%0d: got %b want %b", c, irq, |m_status); end
            n_run++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata_c%0d: got %h want %h", c, rdata, m_rdata); end
            we = 1'b0; re = 1'b0;
            if ($urandom_range(3) == 0) begin
                we = 1'b1; addr = 3'($urandom_range(5, 3)); wdata = W'($urandom);
            end else begin
                re = 1'b1; addr = 3'($urandom_range(7, 0));
            end
            if ($urandom_range(2) == 0) tb_val = tb_val ^ W'($urandom & $urandom);
        end
        we = 1'b0; re = 1'b0;
        @(negedge ck);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        tb_val = '0;
        repeat (10) @(negedge ck);
        wr(3'd5, 8'hFF);
        wr(3'd4, 8'h00);
        wr(3'd3, 8'hFF);
        wr(3'd0, 8'hA5);
        tb_val = 8'hA5;
        wr(3'd1, 8'hFF);
        tb_en = '0;
        repeat (8) @(negedge ck);
        n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        wr(3'd0, 8'h5A);
        repeat (3) @(negedge ck);
        addr = 3'd5; re = 1'b1;
        #2 rstn = 1'b0;
        #1;
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_irq: got %b want 0", irq); end
        n_run++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL async_rdata: got %h want 00", rdata); end
        re = 1'b0; tb_val = 8'h3C; tb_en = '1;
        #1;
        n_run++; if (pad !== 8'h3C) begin n_fail++; $display("FAIL async_pad_released: got %h want 3c", pad); end
        @(negedge ck);
        tb_val = 8'hFF;
        @(negedge ck);
        rstn = 1'b1;
        wr(3'd3, 8'hFF);
        for (int k = 2; k <= 6; k++) begin
            @(negedge ck);
            n_run++;
            if (irq !== (k == 6)) begin n_fail++; $display("FAIL post_reset_rise_edge%0d: got %b want %b", k, irq, k == 6); end
        end
        rd(3'd0, d);
        n_run++; if (d !== 8'h00) begin n_fail++; $display("FAIL post_reset_dout: got %h want 00", d); end
        rd(3'd1, d);
        n_run++; if (d !== 8'h00) begin n_fail++; $display("FAIL post_reset_oe: got %h want 00", d); end
        rd(3'd2, d);
        n_run++; if (d !== 8'hFF) begin n_fail++; $display("FAIL post_reset_din: got %h want ff", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_regs();
        test_rise_latency();
        test_glitch();
        test_w1c_race();
        test_deb0();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter WIDTH, default 32, meaning number of GPIO pins (legal 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, meaning input synchronizer depth in flops (legal 2..4).
REQ-003 Parameter DEB_CYCLES, default 16, meaning debounce persistence in clock cycles (legal 0..65535; 0 = bypass).
REQ-004 CK  in  1  sole clock; all state on rising edge.
REQ-005 RSTN  in  1  reset, asynchronous assert, active-low; deassertion synchronous to CK externally.
REQ-006 PAD  inout  WIDTH  GPIO pins; bit i driven with DOUT[i] when OE[i]=1, else 'z.
REQ-007 ADDR  in  3  register select.
REQ-008 WE  in  1  write strobe, one cycle per write.
REQ-009 RE  in  1  read strobe, one cycle per read.
REQ-010 WDATA  in  WIDTH  write data.
REQ-011 RDATA  out  WIDTH  read data, valid the cycle after RE.
REQ-012 IRQ  out  1  level interrupt, high while any STATUS bit is set.

Function
REQ-013 Register map: 0 DOUT (rw), 1 OE (rw), 2 DIN (ro), 3 RISE_EN (rw), 4 FALL_EN (rw), 5 STATUS (read; write-1-to-clear), 6 SET (wo, DOUT |= WDATA), 7 CLR (wo, DOUT &= ~WDATA).
REQ-014 Reads of 6 and 7 return 0; writes to 2 are ignored.
REQ-015 RDATA registered: value of addressed register at RE edge, presented next cycle; held when RE=0.
REQ-016 Pad input path per bit: SYNC_STAGES-flop synchronizer, then debounce filter, output = DIN.
REQ-017 Debounce per bit: counter increments each cycle synchronized value differs from DIN, clears when equal; DIN[i] toggles on the edge where count reaches DEB_CYCLES, counter clears same edge.
REQ-018 DEB_CYCLES=0: DIN = synchronizer output registered once (no filter).
REQ-019 Latency pad change (stable) to DIN: SYNC_STAGES + max(DEB_CYCLES,1) rising edges.
REQ-020 Glitch shorter than DEB_CYCLES cycles (synchronized) SHALL NOT change DIN or STATUS.
REQ-021 STATUS[i] sets on the edge DIN[i] goes 0->1 with RISE_EN[i]=1, or 1->0 with FALL_EN[i]=1.
REQ-022 STATUS write-1-clear and a new event on the same bit, same cycle: set wins.
REQ-023 Clearing RISE_EN/FALL_EN does not clear pending STATUS.
REQ-024 Output path: write to DOUT/OE/SET/CLR takes effect at PAD one cycle after WE edge.
REQ-025 Pad driven as output is still sampled; DIN reflects driven value after REQ-019 latency.
REQ-026 IRQ = OR of STATUS bits, sourced directly from flops (no input-path combinational logic).
REQ-027 Bits above WIDTH absent; WDATA/RDATA width exactly WIDTH.

Reset
REQ-028 On RSTN low, immediately: DOUT=0, OE=0 (all pads 'z), RISE_EN=0, FALL_EN=0, STATUS=0, RDATA=0, IRQ=0, synchronizers=0, DIN=0, debounce counters=0.
REQ-029 Reset mid-debounce or mid-read aborts operation; no STATUS set or RDATA value survives reset.
REQ-030 After RSTN high, a pad held at 1 produces a DIN 0->1 transition after REQ-019 latency (RISE event if enabled).

Verification
REQ-031 WIDTH=8, DEB_CYCLES=4: write OE=0xFF, DOUT=0xA5; SET 0x0A; CLR 0x01 -> PAD=0xAE, read DOUT=0xAE one cycle after RE.
REQ-032 WIDTH=8, SYNC=2, DEB=4, RISE_EN=0x01: PAD[0] 0->1 held -> DIN[0]=1 and STATUS=0x01, IRQ=1 exactly 6 edges later.
REQ-033 Same config: PAD[0] pulse of 3 cycles -> DIN, STATUS, IRQ unchanged.
REQ-034 STATUS=0x01 pending, FALL_EN=0x01, W1C 0x01 on the edge PAD[0] fall event sets -> STATUS stays 0x01, IRQ stays 1.
REQ-035 DEB=0: PAD toggle -> DIN follows after 3 edges; W1C 0xFF -> STATUS=0, IRQ=0 next cycle.
REQ-036 Assert RSTN mid-debounce with OE=0xFF -> PAD 'z and all outputs 0 without waiting for CK.
